secuenciador_ejecucion: RTL and testbench

//  Execute stage of the 8-bit micro that feeds the combinational ALU. Holds the register file
//  (R0 accumulator + R1..R7), accepts one decoded instruction per valid/ready handshake, drives
//  ALU operands/opcode, then writes Resultado back to R0 and latches Banderas. Sits between the

---
 rtl/uaz_pkg.sv | 31 +++
 rtl/secuenciador_ejecucion_banco_registros.sv | 48 ++++
 rtl/secuenciador_ejecucion.sv | 180 ++++++++++++++++++
 tb/tb_secuenciador_ejecucion.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uaz_pkg.sv
// Shared definitions for the 8-bit micro: default widths, opcode encoding
// (common to the execute stage and the ALU) and the execute-stage FSM states.
package uaz_pkg;

    localparam int ANCHO_DATO_DEF     = 8;
    localparam int NUM_REGS_DEF       = 8;
    localparam int ANCHO_DIR_DEF      = 3;
    localparam int ANCHO_OP_DEF       = 4;
    localparam int ANCHO_BANDERAS_DEF = 3;

    localparam logic [ANCHO_OP_DEF-1:0] OP_NOP    = 4'b0000;
    localparam logic [ANCHO_OP_DEF-1:0] OP_LDI    = 4'b0001;
    localparam logic [ANCHO_OP_DEF-1:0] OP_MOV_R0 = 4'b0010;
    localparam logic [ANCHO_OP_DEF-1:0] OP_MOV_RX = 4'b0011;
    localparam logic [ANCHO_OP_DEF-1:0] OP_SUMA   = 4'b1000;
    localparam logic [ANCHO_OP_DEF-1:0] OP_RESTA  = 4'b1001;
    localparam logic [ANCHO_OP_DEF-1:0] OP_SHL    = 4'b1010;
    localparam logic [ANCHO_OP_DEF-1:0] OP_SHR    = 4'b1011;
    localparam logic [ANCHO_OP_DEF-1:0] OP_NOT    = 4'b1100;
    localparam logic [ANCHO_OP_DEF-1:0] OP_AND    = 4'b1101;
    localparam logic [ANCHO_OP_DEF-1:0] OP_OR     = 4'b1110;
    localparam logic [ANCHO_OP_DEF-1:0] OP_XOR    = 4'b1111;

    typedef enum logic [1:0] {
        EST_IDLE     = 2'd0,
        EST_LEER     = 2'd1,
        EST_EJECUTAR = 2'd2,
        EST_ESCRIBIR = 2'd3
    } estado_t;

endpackage

// File: rtl/secuenciador_ejecucion_banco_registros.sv
// Register file: NUM_REGS x ANCHO_DATO, one synchronous write port,
// two combinational read ports (operand and debug) plus a dedicated R0 tap.
module banco_registros #(
    parameter int ANCHO_DATO = 8,
    parameter int NUM_REGS   = 8,
    parameter int ANCHO_DIR  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ANCHO_DIR-1:0]  wr_dir,
    input  logic [ANCHO_DATO-1:0] wr_dato,
    input  logic [ANCHO_DIR-1:0]  rd_dir,
    output logic [ANCHO_DATO-1:0] rd_dato,
    input  logic [ANCHO_DIR-1:0]  dbg_dir,
    output logic [ANCHO_DATO-1:0] dbg_dato,
    output logic [ANCHO_DATO-1:0] r0
);

    logic [ANCHO_DATO-1:0] regs_q [NUM_REGS];
    logic [ANCHO_DATO-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wr_dir] = wr_dato;
        end
    end

    // NOTE: this array is architectural state that software expects to be zero
    // after reset, so every entry is cleared here rather than left to the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd_dato  = regs_q[rd_dir];
    assign dbg_dato = regs_q[dbg_dir];
    assign r0       = regs_q[0];

endmodule

// File: rtl/secuenciador_ejecucion.sv
// Execute stage: accepts one decoded instruction per handshake, feeds the ALU,
// and retires it by writing the register file and latching the ALU flags.
module secuenciador_ejecucion
    import uaz_pkg::*;
#(
    parameter int ANCHO_DATO     = ANCHO_DATO_DEF,
    parameter int NUM_REGS       = NUM_REGS_DEF,
    parameter int ANCHO_DIR      = ANCHO_DIR_DEF,
    parameter int ANCHO_OP       = ANCHO_OP_DEF,
    parameter int ANCHO_BANDERAS = ANCHO_BANDERAS_DEF
) (
    input  logic                      Reloj,
    input  logic                      Reset_n,
    input  logic                      Instr_valido,
    output logic                      Instr_listo,
    input  logic [ANCHO_OP-1:0]       Instr_op,
    input  logic [ANCHO_DIR-1:0]      Instr_rx,
    input  logic [ANCHO_DATO-1:0]     Instr_inm,
    output logic [ANCHO_DATO-1:0]     ALU_R0,
    output logic [ANCHO_DATO-1:0]     ALU_RX,
    output logic [ANCHO_OP-1:0]       ALU_Operacion,
    input  logic [ANCHO_DATO-1:0]     ALU_Resultado,
    input  logic [ANCHO_BANDERAS-1:0] ALU_Banderas,
    output logic [ANCHO_BANDERAS-1:0] Banderas,
    output logic                      Hecho,
    output logic                      Op_invalida,
    input  logic [ANCHO_DIR-1:0]      Dbg_sel,
    output logic [ANCHO_DATO-1:0]     Dbg_dato
);

    estado_t estado_q, estado_d;

    logic [ANCHO_OP-1:0]       op_q, op_d;
    logic [ANCHO_DIR-1:0]      rx_q, rx_d;
    logic [ANCHO_DATO-1:0]     inm_q, inm_d;
    logic [ANCHO_DATO-1:0]     alu_r0_q, alu_r0_d;
    logic [ANCHO_DATO-1:0]     alu_rx_q, alu_rx_d;
    logic [ANCHO_BANDERAS-1:0] banderas_q, banderas_d;
    logic                      hecho_q, hecho_d;
    logic                      op_invalida_q, op_invalida_d;

    logic                  aceptar;
    logic                  retirar;
    logic                  we;
    logic [ANCHO_DIR-1:0]  wr_dir;
    logic [ANCHO_DATO-1:0] wr_dato;
    logic [ANCHO_DATO-1:0] rd_dato;
    logic [ANCHO_DATO-1:0] r0;

    banco_registros #(
        .ANCHO_DATO (ANCHO_DATO),
        .NUM_REGS   (NUM_REGS),
        .ANCHO_DIR  (ANCHO_DIR)
    ) u_banco (
        .clk      (Reloj),
        .rst_n    (Reset_n),
        .we       (we),
        .wr_dir   (wr_dir),
        .wr_dato  (wr_dato),
        .rd_dir   (rx_q),
        .rd_dato  (rd_dato),
        .dbg_dir  (Dbg_sel),
        .dbg_dato (Dbg_dato),
        .r0       (r0)
    );

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the edge, independent of block order.
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q <= EST_IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            EST_IDLE:     if (aceptar) estado_d = EST_LEER;
            EST_LEER:     estado_d = EST_EJECUTAR;
            EST_EJECUTAR: estado_d = EST_ESCRIBIR;
            EST_ESCRIBIR: estado_d = EST_IDLE;
            default:      estado_d = EST_IDLE;
        endcase
    end

    // The ALU only sees a real opcode while its operands are stable.
    always_comb begin
        Instr_listo   = (estado_q == EST_IDLE);
        retirar       = (estado_q == EST_ESCRIBIR);
        ALU_Operacion = '0;
        if ((estado_q == EST_EJECUTAR || estado_q == EST_ESCRIBIR) && op_q[ANCHO_OP-1]) begin
            ALU_Operacion = op_q;
        end
    end

    assign aceptar = Instr_valido && Instr_listo;

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        op_d          = op_q;
        rx_d          = rx_q;
        inm_d         = inm_q;
        alu_r0_d      = alu_r0_q;
        alu_rx_d      = alu_rx_q;
        banderas_d    = banderas_q;
        hecho_d       = 1'b0;
        op_invalida_d = 1'b0;
        we            = 1'b0;
        wr_dir        = rx_q;
        wr_dato       = inm_q;

        if (aceptar) begin
            op_d  = Instr_op;
            rx_d  = Instr_rx;
            inm_d = Instr_inm;
        end

        if (estado_q == EST_LEER) begin
            alu_r0_d = r0;
            alu_rx_d = rd_dato;
        end

        if (retirar) begin
            hecho_d = 1'b1;
            if (op_q[ANCHO_OP-1]) begin
                we         = 1'b1;
                wr_dir     = '0;
                wr_dato    = ALU_Resultado;
                banderas_d = ALU_Banderas;
            end else begin
                case (op_q)
                    OP_NOP: ;
                    OP_LDI: we = 1'b1;
                    OP_MOV_R0: begin
                        we      = 1'b1;
                        wr_dir  = '0;
                        wr_dato = rd_dato;
                    end
                    OP_MOV_RX: begin
                        we      = 1'b1;
                        wr_dato = r0;
                    end
                    default: op_invalida_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q          <= '0;
            rx_q          <= '0;
            inm_q         <= '0;
            alu_r0_q      <= '0;
            alu_rx_q      <= '0;
            banderas_q    <= '0;
            hecho_q       <= 1'b0;
            op_invalida_q <= 1'b0;
        end else begin
            op_q          <= op_d;
            rx_q          <= rx_d;
            inm_q         <= inm_d;
            alu_r0_q      <= alu_r0_d;
            alu_rx_q      <= alu_rx_d;
            banderas_q    <= banderas_d;
            hecho_q       <= hecho_d;
            op_invalida_q <= op_invalida_d;
        end
    end

    assign ALU_R0      = alu_r0_q;
    assign ALU_RX      = alu_rx_q;
    assign Banderas    = banderas_q;
    assign Hecho       = hecho_q;
    assign Op_invalida = op_invalida_q;

endmodule

// File: tb/tb_secuenciador_ejecucion.sv
// Bench for secuenciador_ejecucion: a behavioural ALU is attached to the DUT and
// results are compared against hand tables and an architectural register model.
module tb_secuenciador_ejecucion;
    import uaz_pkg::*;

    logic       Reloj = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Instr_valido = 1'b0;
    logic       Instr_listo;
    logic [3:0] Instr_op = '0;
    logic [2:0] Instr_rx = '0;
    logic [7:0] Instr_inm = '0;
    logic [7:0] ALU_R0, ALU_RX;
    logic [3:0] ALU_Operacion;
    logic [7:0] ALU_Resultado;
    logic [2:0] ALU_Banderas;
    logic [2:0] Banderas;
    logic       Hecho, Op_invalida;
    logic [2:0] Dbg_sel = '0;
    logic [7:0] Dbg_dato;

    always #5 Reloj = ~Reloj;

    secuenciador_ejecucion dut (
        .Reloj         (Reloj),
        .Reset_n       (Reset_n),
        .Instr_valido  (Instr_valido),
        .Instr_listo   (Instr_listo),
        .Instr_op      (Instr_op),
        .Instr_rx      (Instr_rx),
        .Instr_inm     (Instr_inm),
        .ALU_R0        (ALU_R0),
        .ALU_RX        (ALU_RX),
        .ALU_Operacion (ALU_Operacion),
        .ALU_Resultado (ALU_Resultado),
        .ALU_Banderas  (ALU_Banderas),
        .Banderas      (Banderas),
        .Hecho         (Hecho),
        .Op_invalida   (Op_invalida),
        .Dbg_sel       (Dbg_sel),
        .Dbg_dato      (Dbg_dato)
    );

    // ALU behaviour: flags are {carry/borrow, zero, negative}; shifts use b[2:0]; NOT inverts b.
    function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        s = '0;
        r = '0;
        c = 1'b0;
        case (op)
            OP_SUMA:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            OP_RESTA: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; end
            OP_SHL:   r = a << b[2:0];
            OP_SHR:   r = a >> b[2:0];
            OP_NOT:   r = ~b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            default:  r = '0;
        endcase
        return {c, (r == 8'h00), r[7], r};
    endfunction

    assign {ALU_Banderas, ALU_Resultado} = alu_ref(ALU_Operacion, ALU_R0, ALU_RX);

    logic [7:0] m_regs [8];
    logic [2:0] m_flags;
    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flags = '0;
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] inm);
        logic [10:0] r;
        if (op[3]) begin
            r = alu_ref(op, m_regs[0], m_regs[rx]);
            m_regs[0] = r[7:0];
            m_flags   = r[10:8];
        end else begin
            case (op)
                OP_LDI:    m_regs[rx] = inm;
                OP_MOV_R0: m_regs[0]  = m_regs[rx];
                OP_MOV_RX: m_regs[rx] = m_regs[0];
                default:   ;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_regs(input string tag);
        @(negedge Reloj);
        for (int i = 0; i < 8; i++) begin
            Dbg_sel = 3'(i);
            #1;
            check($sformatf("%s R%0d", tag, i), {24'h0, Dbg_dato}, {24'h0, m_regs[i]});
        end
    endtask

    // Issues one instruction and measures cycles from the accepting edge to Hecho.
    task automatic run_instr(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] inm,
                             input logic [2:0] sel, output int lat, output logic inv,
                             output logic [7:0] dbg_pre, output logic [7:0] dbg_post,
                             output logic hecho_after);
        @(negedge Reloj);
        Instr_op     = op;
        Instr_rx     = rx;
        Instr_inm    = inm;
        Dbg_sel      = sel;
        Instr_valido = 1'b1;
        @(posedge Reloj);
        #1 Instr_valido = 1'b0;
        lat      = 99;
        inv      = 1'b0;
        dbg_pre  = '0;
        dbg_post = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge Reloj);
            #1;
            if (c == 2) dbg_pre = Dbg_dato;
            dbg_post = Dbg_dato;
            if (Hecho) begin
                lat = c;
                inv = Op_invalida;
                break;
            end
        end
        @(posedge Reloj);
        #1 hecho_after = Hecho;
    endtask

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rx;
        logic [7:0] inm;
        logic [2:0] sel;
        logic [7:0] exp_val;
        logic [2:0] exp_flags;
        logic       exp_inv;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic       inv, hecho_after;
        logic [7:0] pre, post, old;
        int         acc [$];
        int         low_cnt, n;
        bit         done;
        logic [3:0] rop;
        logic [2:0] rrx, rsel;
        logic [7:0] rinm;

        tbl[0]  = '{OP_LDI,    3'd1, 8'h03, 3'd1, 8'h03, 3'b000, 1'b0};
        tbl[1]  = '{OP_LDI,    3'd0, 8'h05, 3'd0, 8'h05, 3'b000, 1'b0};
        tbl[2]  = '{OP_SUMA,   3'd1, 8'h00, 3'd0, 8'h08, 3'b000, 1'b0};
        tbl[3]  = '{OP_LDI,    3'd0, 8'h05, 3'd0, 8'h05, 3'b000, 1'b0};
        tbl[4]  = '{OP_RESTA,  3'd1, 8'h00, 3'd0, 8'h02, 3'b000, 1'b0};
        tbl[5]  = '{OP_LDI,    3'd0, 8'h05, 3'd0, 8'h05, 3'b000, 1'b0};
        tbl[6]  = '{OP_SHL,    3'd1, 8'h00, 3'd0, 8'h28, 3'b000, 1'b0};
        tbl[7]  = '{OP_NOT,    3'd1, 8'h00, 3'd0, 8'hFC, 3'b001, 1'b0};
        tbl[8]  = '{OP_LDI,    3'd0, 8'h08, 3'd0, 8'h08, 3'b001, 1'b0};
        tbl[9]  = '{4'b0101,   3'd1, 8'h33, 3'd0, 8'h08, 3'b001, 1'b1};
        tbl[10] = '{OP_LDI,    3'd7, 8'hAA, 3'd7, 8'hAA, 3'b001, 1'b0};
        tbl[11] = '{OP_MOV_R0, 3'd7, 8'h00, 3'd0, 8'hAA, 3'b001, 1'b0};
        tbl[12] = '{OP_SUMA,   3'd7, 8'h00, 3'd0, 8'h54, 3'b100, 1'b0};
        tbl[13] = '{OP_RESTA,  3'd7, 8'h00, 3'd0, 8'hAA, 3'b101, 1'b0};
        tbl[14] = '{OP_MOV_RX, 3'd3, 8'h00, 3'd3, 8'hAA, 3'b101, 1'b0};
        tbl[15] = '{OP_RESTA,  3'd0, 8'h00, 3'd0, 8'h00, 3'b010, 1'b0};
        tbl[16] = '{OP_NOP,    3'd5, 8'h55, 3'd5, 8'h00, 3'b010, 1'b0};
        tbl[17] = '{OP_XOR,    3'd7, 8'h00, 3'd0, 8'hAA, 3'b001, 1'b0};
        tbl[18] = '{4'b0111,   3'd2, 8'h12, 3'd2, 8'h00, 3'b001, 1'b1};

        model_reset();
        repeat (3) @(posedge Reloj);
        #1;
        check("reset listo", {31'h0, Instr_listo}, 32'h1);
        check("reset hecho", {31'h0, Hecho}, 32'h0);
        check("reset banderas", {29'h0, Banderas}, 32'h0);
        check("reset alu_op", {28'h0, ALU_Operacion}, 32'h0);
        @(negedge Reloj) Reset_n = 1'b1;
        check_all_regs("reset");

        // Directed table
        for (int i = 0; i < 19; i++) begin
            old = m_regs[tbl[i].sel];
            run_instr(tbl[i].op, tbl[i].rx, tbl[i].inm, tbl[i].sel, lat, inv, pre, post, hecho_after);
            model_exec(tbl[i].op, tbl[i].rx, tbl[i].inm);
            check($sformatf("tbl%0d latency", i), lat, 3);
            check($sformatf("tbl%0d hecho pulse", i), {31'h0, hecho_after}, 32'h0);
            check($sformatf("tbl%0d op_invalida", i), {31'h0, inv}, {31'h0, tbl[i].exp_inv});
            check($sformatf("tbl%0d dbg pre-write", i), {24'h0, pre}, {24'h0, old});
            check($sformatf("tbl%0d result", i), {24'h0, post}, {24'h0, tbl[i].exp_val});
            check($sformatf("tbl%0d banderas", i), {29'h0, Banderas}, {29'h0, tbl[i].exp_flags});
        end
        check_all_regs("after table");

        // Back-to-back: valid held high, five LDIs
        low_cnt = 0;
        n = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge Reloj);
            if (Instr_listo) begin
                if (n < 5) begin
                    Instr_op     = OP_LDI;
                    Instr_rx     = 3'(n + 1);
                    Instr_inm    = 8'(17 * (n + 1));
                    Instr_valido = 1'b1;
                    model_exec(OP_LDI, 3'(n + 1), 8'(17 * (n + 1)));
                    acc.push_back(cyc);
                    n++;
                end else begin
                    Instr_valido = 1'b0;
                    done = 1'b1;
                end
            end else begin
                low_cnt++;
            end
        end
        check("b2b accepted", n, 5);
        check("b2b listo low cycles", low_cnt, 15);
        for (int i = 1; i < acc.size(); i++) begin
            check($sformatf("b2b spacing %0d", i), acc[i] - acc[i-1], 4);
        end
        check_all_regs("after b2b");

        // Reset asserted during EJECUTAR of a SUMA
        @(negedge Reloj);
        Instr_op     = OP_SUMA;
        Instr_rx     = 3'd1;
        Instr_valido = 1'b1;
        Dbg_sel      = 3'd0;
        @(posedge Reloj);
        #1 Instr_valido = 1'b0;
        @(posedge Reloj);
        #1 check("ejecutar alu_op", {28'h0, ALU_Operacion}, {28'h0, OP_SUMA});
        @(negedge Reloj);
        Reset_n      = 1'b0;
        Instr_op     = OP_LDI;
        Instr_rx     = 3'd2;
        Instr_inm    = 8'h77;
        Instr_valido = 1'b1;
        #1;
        model_reset();
        check("abort R0", {24'h0, Dbg_dato}, 32'h0);
        check("abort banderas", {29'h0, Banderas}, 32'h0);
        check("abort alu_r0", {24'h0, ALU_R0}, 32'h0);
        check("abort alu_op", {28'h0, ALU_Operacion}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge Reloj);
            #1;
            check("abort hecho", {31'h0, Hecho}, 32'h0);
            check("abort listo", {31'h0, Instr_listo}, 32'h1);
        end
        @(negedge Reloj) Reset_n = 1'b1;
        @(posedge Reloj);
        #1 Instr_valido = 1'b0;
        check("release accepted", {31'h0, Instr_listo}, 32'h0);
        lat = 99;
        for (int c = 1; c <= 6; c++) begin
            @(posedge Reloj);
            #1;
            if (Hecho) begin
                lat = c;
                break;
            end
        end
        check("release latency", lat, 3);
        model_exec(OP_LDI, 3'd2, 8'h77);
        check_all_regs("after reset");

        // Randomised instructions against the register model
        for (int i = 0; i < 48; i++) begin
            rop  = 4'($urandom_range(0, 15));
            rrx  = 3'($urandom_range(0, 7));
            rinm = 8'($urandom_range(0, 255));
            rsel = 3'($urandom_range(0, 7));
            old  = m_regs[rsel];
            run_instr(rop, rrx, rinm, rsel, lat, inv, pre, post, hecho_after);
            model_exec(rop, rrx, rinm);
            check($sformatf("rnd%0d op%0h latency", i, rop), lat, 3);
            check($sformatf("rnd%0d op%0h op_invalida", i, rop), {31'h0, inv}, {31'h0, (rop[3:2] == 2'b01)});
            check($sformatf("rnd%0d op%0h dbg pre-write", i, rop), {24'h0, pre}, {24'h0, old});
            check($sformatf("rnd%0d op%0h R%0d", i, rop, rsel), {24'h0, post}, {24'h0, m_regs[rsel]});
            check($sformatf("rnd%0d op%0h banderas", i, rop), {29'h0, Banderas}, {29'h0, m_flags});
            if (i % 12 == 11) check_all_regs("random sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
